// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU datapath types
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_LOAD,
    WRITE
  } wb_state_t;
endpackage

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - pending register-write vector for decode hazard checks
module wb_scoreboard
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        set_en,
  input  regbits_t    set_idx,
  input  logic        clr_en,
  input  regbits_t    clr_idx,
  output logic [31:0] pending
);

  logic [31:0] pending_q;
  logic [31:0] pending_d;

  // Set is applied after clear so a newer producer to the same register stays outstanding.
  always_comb begin
    pending_d = pending_q;
    if (clr_en) begin
      pending_d[clr_idx] = 1'b0;
    end
    if (set_en && (set_idx != '0)) begin
      pending_d[set_idx] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - writeback FSM driving the register file write port
module regfile_writeback
  import cpu_types_pkg::*;
#(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 7
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic        mem_regwrite,
  input  logic        mem_memtoreg,
  input  logic [4:0]  mem_wsel,
  input  logic [31:0] mem_result,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  input  logic        issue_valid,
  input  logic [4:0]  issue_wsel,
  output logic        rf_WEN,
  output logic [4:0]  rf_wsel,
  output logic [31:0] rf_wdat,
  output logic [31:0] pending,
  output logic        load_timeout
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  wb_state_t         state_q, state_d;
  logic              rf_wen_q, rf_wen_d;
  regbits_t          rf_wsel_q, rf_wsel_d;
  word_t             rf_wdat_q, rf_wdat_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              load_timeout_q, load_timeout_d;
  logic              accept;

  assign mem_ready = (state_q == IDLE) || (state_q == WRITE);
  assign accept    = mem_valid && mem_ready;

  always_comb begin
    state_d   = state_q;
    rf_wen_d  = 1'b0;
    rf_wsel_d = rf_wsel_q;
    rf_wdat_d = rf_wdat_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE, WRITE: begin
        state_d = IDLE;
        if (accept && mem_regwrite) begin
          rf_wsel_d = mem_wsel;
          if (mem_memtoreg) begin
            state_d = WAIT_LOAD;
            cnt_d   = '0;
          end else begin
            state_d   = WRITE;
            rf_wdat_d = mem_result;
            rf_wen_d  = (mem_wsel != '0);
          end
        end
      end
      WAIT_LOAD: begin
        if (dhit) begin
          state_d   = WRITE;
          rf_wdat_d = dmemload;
          rf_wen_d  = (rf_wsel_q != '0);
        end else if (cnt_q != MAX_CNT) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // The counter only saturates inside a load wait, so this flag is sticky until reset.
    load_timeout_d = load_timeout_q || (cnt_d == MAX_CNT);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q        <= IDLE;
      rf_wen_q       <= 1'b0;
      rf_wsel_q      <= '0;
      rf_wdat_q      <= '0;
      cnt_q          <= '0;
      load_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      rf_wen_q       <= rf_wen_d;
      rf_wsel_q      <= rf_wsel_d;
      rf_wdat_q      <= rf_wdat_d;
      cnt_q          <= cnt_d;
      load_timeout_q <= load_timeout_d;
    end
  end

  wb_scoreboard u_scoreboard (
    .CLK     (CLK),
    .nRST    (nRST),
    .set_en  (issue_valid),
    .set_idx (issue_wsel),
    .clr_en  (state_q == WRITE),
    .clr_idx (rf_wsel_q),
    .pending (pending)
  );

  assign rf_WEN       = rf_wen_q;
  assign rf_wsel      = rf_wsel_q;
  assign rf_wdat      = rf_wdat_q;
  assign load_timeout = load_timeout_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// tb/tb_regfile_writeback.sv - directed self-checking bench for regfile_writeback
module tb_regfile_writeback;

  logic        CLK;
  logic        nRST;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_regwrite;
  logic        mem_memtoreg;
  logic [4:0]  mem_wsel;
  logic [31:0] mem_result;
  logic        dhit;
  logic [31:0] dmemload;
  logic        issue_valid;
  logic [4:0]  issue_wsel;
  logic        rf_WEN;
  logic [4:0]  rf_wsel;
  logic [31:0] rf_wdat;
  logic [31:0] pending;
  logic        load_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_writeback #(.MAX_WAIT(64), .CNT_W(7)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_regwrite (mem_regwrite),
    .mem_memtoreg (mem_memtoreg),
    .mem_wsel     (mem_wsel),
    .mem_result   (mem_result),
    .dhit         (dhit),
    .dmemload     (dmemload),
    .issue_valid  (issue_valid),
    .issue_wsel   (issue_wsel),
    .rf_WEN       (rf_WEN),
    .rf_wsel      (rf_wsel),
    .rf_wdat      (rf_wdat),
    .pending      (pending),
    .load_timeout (load_timeout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [4:0] wsel);
    issue_valid = 1'b1;
    issue_wsel  = wsel;
    @(negedge CLK);
    issue_valid = 1'b0;
  endtask

  typedef struct {
    logic        rw;
    logic [4:0]  wsel;
    logic [31:0] res;
    logic        exp_wen;
    logic        chk_dat;
    logic        exp_pend_set;
    logic        exp_pend_after;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 5'd0,  32'h00001234, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 5'd9,  32'h0000AAAA, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 5'd1,  32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0};

    nRST = 1'b0;
    mem_valid = 1'b0; mem_regwrite = 1'b0; mem_memtoreg = 1'b0;
    mem_wsel = '0; mem_result = '0; dhit = 1'b0; dmemload = '0;
    issue_valid = 1'b0; issue_wsel = '0;
    repeat (2) @(negedge CLK);
    check("rst_wen", 32'(rf_WEN), 32'd0);
    check("rst_wsel", 32'(rf_wsel), 32'd0);
    check("rst_wdat", rf_wdat, 32'd0);
    check("rst_pending", pending, 32'd0);
    check("rst_timeout", 32'(load_timeout), 32'd0);
    nRST = 1'b1;
    @(negedge CLK);
    check("rst_ready", 32'(mem_ready), 32'd1);

    // Single ALU / no-write transfers from IDLE
    for (int i = 0; i < 5; i++) begin
      issue(vecs[i].wsel);
      check($sformatf("v%0d_pend_set", i), 32'(pending[vecs[i].wsel]), 32'(vecs[i].exp_pend_set));
      mem_valid = 1'b1; mem_regwrite = vecs[i].rw; mem_memtoreg = 1'b0;
      mem_wsel = vecs[i].wsel; mem_result = vecs[i].res;
      @(negedge CLK);
      mem_valid = 1'b0;
      check($sformatf("v%0d_wen", i), 32'(rf_WEN), 32'(vecs[i].exp_wen));
      check($sformatf("v%0d_ready", i), 32'(mem_ready), 32'd1);
      if (vecs[i].chk_dat) begin
        check($sformatf("v%0d_wsel", i), 32'(rf_wsel), 32'(vecs[i].wsel));
        check($sformatf("v%0d_wdat", i), rf_wdat, vecs[i].res);
      end
      @(negedge CLK);
      check($sformatf("v%0d_wen_off", i), 32'(rf_WEN), 32'd0);
      check($sformatf("v%0d_pend_after", i), 32'(pending[vecs[i].wsel]), 32'(vecs[i].exp_pend_after));
    end
    check("table_pending", pending, 32'h0000_0200);

    // dhit in IDLE is ignored
    dhit = 1'b1; dmemload = 32'hBAD0BAD0;
    @(negedge CLK);
    dhit = 1'b0;
    check("idle_dhit_wen", 32'(rf_WEN), 32'd0);

    // Load to $8, 3 wait cycles, with an ALU op to $20 held upstream meanwhile
    mem_valid = 1'b1; mem_regwrite = 1'b1; mem_memtoreg = 1'b1; mem_wsel = 5'd8; mem_result = 32'h0;
    @(negedge CLK);
    mem_memtoreg = 1'b0; mem_wsel = 5'd20; mem_result = 32'h00C0FFEE;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("ld_wait%0d_ready", k), 32'(mem_ready), 32'd0);
      check($sformatf("ld_wait%0d_wen", k), 32'(rf_WEN), 32'd0);
      @(negedge CLK);
    end
    dhit = 1'b1; dmemload = 32'h12345678;
    @(negedge CLK);
    dhit = 1'b0;
    check("ld_wen", 32'(rf_WEN), 32'd1);
    check("ld_wsel", 32'(rf_wsel), 32'd8);
    check("ld_wdat", rf_wdat, 32'h12345678);
    check("ld_ready", 32'(mem_ready), 32'd1);
    @(negedge CLK);
    mem_valid = 1'b0;
    check("held_wen", 32'(rf_WEN), 32'd1);
    check("held_wsel", 32'(rf_wsel), 32'd20);
    check("held_wdat", rf_wdat, 32'h00C0FFEE);
    @(negedge CLK);
    check("held_wen_off", 32'(rf_WEN), 32'd0);

    // Back-to-back ALU ops to $3 then $4
    mem_valid = 1'b1; mem_regwrite = 1'b1; mem_wsel = 5'd3; mem_result = 32'h33333333;
    @(negedge CLK);
    check("b2b_a_wen", 32'(rf_WEN), 32'd1);
    check("b2b_a_wsel", 32'(rf_wsel), 32'd3);
    check("b2b_a_ready", 32'(mem_ready), 32'd1);
    mem_wsel = 5'd4; mem_result = 32'h44444444;
    @(negedge CLK);
    mem_valid = 1'b0;
    check("b2b_b_wen", 32'(rf_WEN), 32'd1);
    check("b2b_b_wsel", 32'(rf_wsel), 32'd4);
    check("b2b_b_wdat", rf_wdat, 32'h44444444);
    @(negedge CLK);
    check("b2b_wen_off", 32'(rf_WEN), 32'd0);

    // Scoreboard race: reissue $7 during the write to $7
    issue(5'd7);
    check("race_pend_set", 32'(pending[7]), 32'd1);
    mem_valid = 1'b1; mem_regwrite = 1'b1; mem_wsel = 5'd7; mem_result = 32'h77;
    @(negedge CLK);
    mem_valid = 1'b0;
    check("race_wen", 32'(rf_WEN), 32'd1);
    issue(5'd7);
    check("race_pend_kept", 32'(pending[7]), 32'd1);

    // Load timeout
    mem_valid = 1'b1; mem_regwrite = 1'b1; mem_memtoreg = 1'b1; mem_wsel = 5'd10;
    @(negedge CLK);
    mem_valid = 1'b0; mem_memtoreg = 1'b0;
    repeat (63) @(negedge CLK);
    check("to_63_flag", 32'(load_timeout), 32'd0);
    @(negedge CLK);
    check("to_64_flag", 32'(load_timeout), 32'd1);
    check("to_64_ready", 32'(mem_ready), 32'd0);
    repeat (10) @(negedge CLK);
    check("to_sat_ready", 32'(mem_ready), 32'd0);
    dhit = 1'b1; dmemload = 32'h0000ABCD;
    @(negedge CLK);
    dhit = 1'b0;
    check("to_wen", 32'(rf_WEN), 32'd1);
    check("to_wsel", 32'(rf_wsel), 32'd10);
    check("to_wdat", rf_wdat, 32'h0000ABCD);
    @(negedge CLK);
    check("to_sticky", 32'(load_timeout), 32'd1);

    // Asynchronous reset in the middle of a load wait
    issue(5'd12);
    mem_valid = 1'b1; mem_regwrite = 1'b1; mem_memtoreg = 1'b1; mem_wsel = 5'd8;
    @(negedge CLK);
    mem_valid = 1'b0; mem_memtoreg = 1'b0;
    @(negedge CLK);
    check("mid_ready", 32'(mem_ready), 32'd0);
    check("mid_pend12", 32'(pending[12]), 32'd1);
    #2 nRST = 1'b0;
    #1;
    check("arst_wen", 32'(rf_WEN), 32'd0);
    check("arst_pending", pending, 32'd0);
    check("arst_timeout", 32'(load_timeout), 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    check("arst_ready", 32'(mem_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
